// File: rtl/crc16_serial_checker_if.sv
// Serial CRC-16 checker link: frame input bits plus the per-frame verdict.
interface crc16_serial_checker_if #(
  parameter int CNT_W = 16
);
  logic             load;
  logic             d_valid;
  logic             crc_in;
  logic             d_finish;
  logic             check_done;
  logic             crc_ok;
  logic             crc_err;
  logic             short_err;
  logic [15:0]      remainder;
  logic [CNT_W-1:0] bit_count;

  // Frame source side: drives the serial stream, observes the verdict.
  modport master (
    output load, d_valid, crc_in, d_finish,
    input  check_done, crc_ok, crc_err, short_err, remainder, bit_count
  );

  // Checker side.
  modport slave (
    input  load, d_valid, crc_in, d_finish,
    output check_done, crc_ok, crc_err, short_err, remainder, bit_count
  );
endinterface

// File: rtl/crc16_serial_checker.sv
// Receive-side serial CRC-16 checker. Runs the generator's LFSR over data
// plus appended CRC bits (MSB first); a clean frame leaves a zero remainder.
module crc16_serial_checker #(
  parameter logic [15:0] POLY  = 16'h1021,
  parameter logic [15:0] INIT  = 16'h0000,
  parameter int          CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  crc16_serial_checker_if.slave bus
);

  // A frame needs at least one data bit on top of the 16 CRC bits.
  localparam logic [CNT_W-1:0] MIN_BITS = CNT_W'(17);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  // One non-reflected LFSR step with the incoming bit folded into feedback.
  function automatic logic [15:0] crc_step(input logic [15:0] r, input logic b);
    logic fb;
    fb = r[15] ^ b;
    return {r[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  endfunction

  // Counter increment that sticks at all ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t           state_p1, state_nx;
  logic [15:0]      lfsr_p1, lfsr_nx, lfsr_p0;
  logic [CNT_W-1:0] cnt_p1, cnt_nx, cnt_p0;
  logic             done_p1, done_nx;
  logic             ok_p1, ok_nx;
  logic             err_p1, err_nx;
  logic             short_p1, short_nx;
  logic             vld_p0, short_p0, ok_p0;

  // ---- p0: LFSR/count including this cycle's bit (the verdict looks here) ----
  assign vld_p0   = bus.d_valid;
  assign lfsr_p0  = vld_p0 ? crc_step(lfsr_p1, bus.crc_in) : lfsr_p1;
  assign cnt_p0   = vld_p0 ? sat_inc(cnt_p1) : cnt_p1;
  assign short_p0 = (cnt_p0 < MIN_BITS);
  assign ok_p0    = !short_p0 && (lfsr_p0 == 16'h0000);

  // Next-state logic: load always restarts a frame, even over d_finish.
  always_comb begin
    state_nx = state_p1;
    lfsr_nx  = lfsr_p1;
    cnt_nx   = cnt_p1;
    done_nx  = 1'b0;
    ok_nx    = ok_p1;
    err_nx   = err_p1;
    short_nx = short_p1;
    if (bus.load) begin
      state_nx = RECV;
      lfsr_nx  = INIT;
      cnt_nx   = '0;
      ok_nx    = 1'b0;
      err_nx   = 1'b0;
      short_nx = 1'b0;
    end else begin
      case (state_p1)
        RECV: begin
          lfsr_nx = lfsr_p0;
          cnt_nx  = cnt_p0;
          if (bus.d_finish) begin
            state_nx = DONE;
            done_nx  = 1'b1;
            ok_nx    = ok_p0;
            err_nx   = !ok_p0;
            short_nx = short_p0;
          end
        end
        IDLE:    state_nx = IDLE;
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // ---- p1: registered FSM state, LFSR, counter and held verdict ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= IDLE;
      lfsr_p1  <= INIT;
      cnt_p1   <= '0;
      done_p1  <= 1'b0;
      ok_p1    <= 1'b0;
      err_p1   <= 1'b0;
      short_p1 <= 1'b0;
    end else begin
      state_p1 <= state_nx;
      lfsr_p1  <= lfsr_nx;
      cnt_p1   <= cnt_nx;
      done_p1  <= done_nx;
      ok_p1    <= ok_nx;
      err_p1   <= err_nx;
      short_p1 <= short_nx;
    end
  end

  assign bus.check_done = done_p1;
  assign bus.crc_ok     = ok_p1;
  assign bus.crc_err    = err_p1;
  assign bus.short_err  = short_p1;
  assign bus.remainder  = lfsr_p1;
  assign bus.bit_count  = cnt_p1;

endmodule

// File: tb/tb_crc16_serial_checker.sv
// Directed bench for crc16_serial_checker: table of whole frames plus
// hand-written restart, collision and reset sequences.
module tb_crc16_serial_checker;

  localparam logic [15:0] POLY = 16'h1021;
  localparam int          NB   = 88;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  // "123456789" followed by its CRC-16/XMODEM value.
  logic [NB-1:0] frame = {"123456789", 16'h31C3};

  crc16_serial_checker_if #(.CNT_W(16)) bus ();

  crc16_serial_checker #(.POLY(16'h1021), .INIT(16'h0000), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          nbits;
    bit          zero;   // send all-zero bits instead of the reference frame
    int          flip;   // index of inverted bit, -1 for none
    bit          gap;    // d_valid low on every third cycle
    int          pre;    // bits of an aborted frame before the real one
    bit          ok;
    bit          err;
    bit          sht;
    logic [15:0] rem;
    int          cnt;
  } vec_t;

  vec_t vecs[5];

  // x^k mod G: the remainder contributed by a lone 1 at weight x^k.
  function automatic logic [15:0] xpow(input int k);
    logic [15:0] r;
    r = 16'h0001;
    for (int i = 0; i < k; i++) r = r[15] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  function automatic logic get_bit(input int idx, input bit zero, input int flip);
    logic b;
    b = zero ? 1'b0 : frame[NB-1-idx];
    return b ^ (idx == flip);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load = 1'b0; bus.d_valid = 1'b0; bus.crc_in = 1'b0; bus.d_finish = 1'b0;
  endtask

  task automatic pulse_load();
    bus.load = 1'b1; bus.d_valid = 1'b1; bus.crc_in = 1'b1; bus.d_finish = 1'b0;
    tick();
    idle_inputs();
  endtask

  task automatic send_bits(input int n, input bit zero, input int flip, input bit gap, input bit fin);
    int i;
    int c;
    i = 0;
    c = 0;
    while (i < n) begin
      if (gap && (c % 3 == 2)) begin
        bus.d_valid = 1'b0; bus.crc_in = c[0]; bus.d_finish = 1'b0;
      end else begin
        bus.d_valid = 1'b1; bus.crc_in = get_bit(i, zero, flip);
        bus.d_finish = fin && (i == n - 1);
        i++;
      end
      c++;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"pass",    NB, 1'b0, -1, 1'b0,  0, 1'b1, 1'b0, 1'b0, 16'h0000, NB};
    vecs[1] = '{"biterr",  NB, 1'b0,  5, 1'b0,  0, 1'b0, 1'b1, 1'b0, xpow(NB - 1 - 5 + 16), NB};
    vecs[2] = '{"short",    8, 1'b1, -1, 1'b0,  0, 1'b0, 1'b1, 1'b1, 16'h0000, 8};
    vecs[3] = '{"gapped",  NB, 1'b0, -1, 1'b1,  0, 1'b1, 1'b0, 1'b0, 16'h0000, NB};
    vecs[4] = '{"restart", NB, 1'b0, -1, 1'b0, 30, 1'b1, 1'b0, 1'b0, 16'h0000, NB};

    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_done",  {31'd0, bus.check_done}, 32'd0);
    chk("rst_ok",    {31'd0, bus.crc_ok},     32'd0);
    chk("rst_err",   {31'd0, bus.crc_err},    32'd0);
    chk("rst_short", {31'd0, bus.short_err},  32'd0);
    chk("rst_rem",   {16'd0, bus.remainder},  32'h0000);
    chk("rst_cnt",   {16'd0, bus.bit_count},  32'd0);

    for (int v = 0; v < 5; v++) begin
      pulse_load();
      if (vecs[v].pre > 0) begin
        send_bits(vecs[v].pre, vecs[v].zero, -1, 1'b0, 1'b0);
        pulse_load();
      end
      send_bits(vecs[v].nbits, vecs[v].zero, vecs[v].flip, vecs[v].gap, 1'b1);
      chk({vecs[v].name, "_done"},  {31'd0, bus.check_done}, 32'd1);
      chk({vecs[v].name, "_ok"},    {31'd0, bus.crc_ok},     {31'd0, vecs[v].ok});
      chk({vecs[v].name, "_err"},   {31'd0, bus.crc_err},    {31'd0, vecs[v].err});
      chk({vecs[v].name, "_short"}, {31'd0, bus.short_err},  {31'd0, vecs[v].sht});
      chk({vecs[v].name, "_rem"},   {16'd0, bus.remainder},  {16'd0, vecs[v].rem});
      chk({vecs[v].name, "_cnt"},   {16'd0, bus.bit_count},  vecs[v].cnt);
      if (vecs[v].flip >= 0)
        chk({vecs[v].name, "_rem_nz"}, {31'd0, (bus.remainder != 16'h0000)}, 32'd1);
      // DONE must ignore further bits and end-of-frame marks.
      bus.d_valid = 1'b1; bus.crc_in = 1'b1; bus.d_finish = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        chk({vecs[v].name, "_hold_done"}, {31'd0, bus.check_done}, 32'd0);
      end
      idle_inputs();
      chk({vecs[v].name, "_hold_ok"},  {31'd0, bus.crc_ok},    {31'd0, vecs[v].ok});
      chk({vecs[v].name, "_hold_err"}, {31'd0, bus.crc_err},   {31'd0, vecs[v].err});
      chk({vecs[v].name, "_hold_rem"}, {16'd0, bus.remainder}, {16'd0, vecs[v].rem});
      chk({vecs[v].name, "_hold_cnt"}, {16'd0, bus.bit_count}, vecs[v].cnt);
    end

    // load coincident with d_finish: no verdict, fresh frame in RECV.
    pulse_load();
    send_bits(10, 1'b0, -1, 1'b0, 1'b0);
    bus.load = 1'b1; bus.d_valid = 1'b1; bus.crc_in = 1'b1; bus.d_finish = 1'b1;
    tick();
    idle_inputs();
    chk("coll_done", {31'd0, bus.check_done}, 32'd0);
    chk("coll_cnt",  {16'd0, bus.bit_count},  32'd0);
    chk("coll_ok",   {31'd0, bus.crc_ok},     32'd0);
    chk("coll_err",  {31'd0, bus.crc_err},    32'd0);
    chk("coll_rem",  {16'd0, bus.remainder},  32'h0000);
    // Still receiving: a bare finish now yields a short-frame verdict.
    bus.d_finish = 1'b1;
    tick();
    idle_inputs();
    chk("coll_fin_done",  {31'd0, bus.check_done}, 32'd1);
    chk("coll_fin_short", {31'd0, bus.short_err},  32'd1);
    chk("coll_fin_err",   {31'd0, bus.crc_err},    32'd1);
    chk("coll_fin_ok",    {31'd0, bus.crc_ok},     32'd0);
    tick();
    chk("coll_pulse_end", {31'd0, bus.check_done}, 32'd0);

    // Reset in the middle of a frame, then a finish with no load.
    pulse_load();
    send_bits(40, 1'b0, -1, 1'b0, 1'b0);
    chk("mid_cnt", {16'd0, bus.bit_count}, 32'd40);
    rst = 1'b1; bus.d_valid = 1'b1; bus.crc_in = 1'b1; bus.load = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    chk("mrst_done",  {31'd0, bus.check_done}, 32'd0);
    chk("mrst_ok",    {31'd0, bus.crc_ok},     32'd0);
    chk("mrst_err",   {31'd0, bus.crc_err},    32'd0);
    chk("mrst_short", {31'd0, bus.short_err},  32'd0);
    chk("mrst_rem",   {16'd0, bus.remainder},  32'h0000);
    chk("mrst_cnt",   {16'd0, bus.bit_count},  32'd0);
    bus.d_finish = 1'b1; bus.d_valid = 1'b1; bus.crc_in = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("idle_fin_done", {31'd0, bus.check_done}, 32'd0);
      chk("idle_fin_cnt",  {16'd0, bus.bit_count},  32'd0);
    end
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
